// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait latency.
// Ports: req_* request channel in, rsp_* response channel out, busy status.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be 0..15");
    end
    if (DEPTH_WORDS < 4 || DEPTH_WORDS > 4096 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of 2 in 4..4096");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        armed_q;
    logic        accept, access, clear;

    logic        lat_wr;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        a_wr;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [AW-1:0] a_idx;
    logic        a_err;

    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    // armed_q keeps req_ready low until the first edge after reset release
    assign req_ready = armed_q && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    cnt_d  = LAT;
                    if (LAT == 4'd0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency accesses use the live request, others the latched copy
    always_comb begin
        a_wr    = accept ? req_wr    : lat_wr;
        a_addr  = accept ? req_addr  : lat_addr;
        a_wdata = accept ? req_wdata : lat_wdata;
        a_be    = accept ? req_be    : lat_be;
    end

    assign a_idx = a_addr[AW+1:2];
    assign a_err = (a_addr[1:0] != 2'b00) || (|a_addr[31:AW+2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            if (accept) begin
                lat_wr    <= req_wr;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (access) begin
                err_q   <= a_err;
                rdata_q <= (a_err || a_wr) ? 32'h0 : mem[a_idx];
            end else if (clear) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (access && a_wr && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) begin
                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances.
// Inputs are shared; sel routes handshakes and outputs to one instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        va, vb, ra, rb;
    logic        rdy_a, rdy_b, val_a, val_b, err_a, err_b;
    logic        busy_a, busy_b;
    logic [31:0] rd_a, rd_b;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign va = req_valid & ~sel;
    assign vb = req_valid & sel;
    assign ra = rsp_ready & ~sel;
    assign rb = rsp_ready & sel;

    assign req_ready = sel ? rdy_b : rdy_a;
    assign rsp_valid = sel ? val_b : val_a;
    assign rsp_rdata = sel ? rd_b  : rd_a;
    assign rsp_err   = sel ? err_b : err_a;
    assign busy      = sel ? busy_b : busy_a;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(va), .req_ready(rdy_a),
        .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(val_a), .rsp_ready(ra),
        .rsp_rdata(rd_a), .rsp_err(err_a),
        .busy(busy_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(vb), .req_ready(rdy_b),
        .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(val_b), .rsp_ready(rb),
        .rsp_rdata(rd_b), .rsp_err(err_b),
        .busy(busy_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [3:0] be,
                          output logic [31:0] rd,
                          output logic er,
                          output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // full-word store then load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("st10_lat", 32'(lat), 32'd3);
        chk("st10_err", 32'(er), 32'd0);
        chk("st10_rdata", rd, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ld10_lat", 32'(lat), 32'd3);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        chk("ld10_err", 32'(er), 32'd0);

        // byte-lane merge
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("ld20_merge", rd, 32'h11BB33DD);

        // empty byte enable leaves data alone
        do_req(1'b1, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("be0_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("be0_keep", rd, 32'hDEADBEEF);

        // error cases
        do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'h0);
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'h0);
        do_req(1'b1, 32'h11, 32'h01010101, 4'hF, rd, er, lat);
        chk("mis_st_err", 32'(er), 32'd1);
        do_req(1'b1, 32'h410, 32'h55555555, 4'hF, rd, er, lat);
        chk("oor_st_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("err_nochg", rd, 32'hDEADBEEF);

        // response back-pressure
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        chk("bp_valid0", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h11BB33DD);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("hs_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("hs_valid", 32'(rsp_valid), 32'd0);
        chk("hs_rdata", rsp_rdata, 32'h0);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_rdy1", 32'(req_ready), 32'd1);

        // zero latency instance
        sel = 1'b1;
        do_req(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, er, lat);
        chk("l0_st_lat", 32'(lat), 32'd1);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h8;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_ready", 32'(req_ready), 32'(i % 2 == 0));
            chk("b2b_valid", 32'(rsp_valid), 32'(i % 2 == 1));
            if (i % 2 == 1) chk("b2b_rdata", rsp_rdata, 32'hCAFEF00D);
            if (i < 5) @(negedge clk);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        sel = 1'b0;

        // reset during WAIT abandons the store
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        chk("abandon_st", rd, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rezero", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port; the CPU is the initiator.
- Accepts one load/store request through a valid/ready handshake.
- Holds the request for a programmable number of wait cycles, then performs the access on internal word storage.
- Returns the result through a valid/ready response channel, giving later multi-cycle CPU versions a memory with realistic, stall-inducing latency.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words of storage; must be a power of 2, 4..4096.
- LATENCY, 2: wait cycles between request accept and access, 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  output  1  response is available.
- rsp_ready  input  1  CPU accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - While rst is low, asynchronously: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, wait counter = 0, all storage words = 0.
  - req_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a clock edge with req_valid = 1, the request is accepted: latch req_wr, req_addr, req_wdata and req_be; load the counter with LATENCY.
  - If LATENCY = 0, perform the access and go to RESP; otherwise go to WAIT.
  - Inputs are ignored whenever req_ready = 0.
- WAIT:
  - req_ready = 0. Decrement the counter each edge.
  - On the edge where the counter equals 1, perform the access and go to RESP.
- Latency:
  - If the request is accepted on edge E, rsp_valid is high in the cycle following edge E+LATENCY.
  - With LATENCY = 0 the response appears in the next cycle.
- Access, performed on the latched request:
  - Error condition: addr[1:0] != 0, or addr >= 4*DEPTH_WORDS.
    - rsp_err = 1, rsp_rdata = 0, no storage change.
  - Otherwise the word index is addr[log2(DEPTH_WORDS)+1:2].
  - Load: rsp_rdata = stored word, rsp_err = 0.
  - Store: each enabled byte lane is replaced with the corresponding req_wdata byte; other lanes are unchanged; rsp_rdata = 0, rsp_err = 0.
  - A store with be = 4'b0000 is legal: no change, normal response.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready = 1, go to IDLE, clear rsp_valid, rsp_rdata and rsp_err.
  - No new request is accepted in that same cycle (req_ready is still 0); the next accept is possible one cycle later.
- Outstanding requests: at most one; no pipelining; requests never reorder.
- Reset mid-operation:
  - If reset hits in WAIT, the pending access is abandoned and no store is committed.
  - If reset hits in RESP, the pending response is dropped.
  - Storage is re-zeroed in both cases.
- Counter width is 4 bits; LATENCY values above 15 are a configuration error (checked at elaboration).

Test Plan:
- LATENCY=2, store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 → load rsp_valid three cycles after its accept edge; rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Preload word 0x20 = 0x11223344; store be 4'b0101, wdata 0xAABBCCDD; load 0x20 → 0x11BB33DD.
- Load addr 0x13 (misaligned), then load addr 4*DEPTH_WORDS → rsp_err = 1 and rsp_rdata = 0 for both; storage unchanged.
- Hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready = 0; raise rsp_ready → IDLE, then req_ready = 1 one cycle later.
- LATENCY=0, back-to-back loads with req_valid held high → each response in the cycle after its accept; accepts spaced one cycle after each response handshake.
- Store issued, rst pulled low during WAIT → all outputs 0 immediately; after release, a load of that address returns 0.
